apb_slave_mem: RTL
==================

APB_SLAVE_MEM -- requirements
Module: apb_slave_mem

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 32: paddr width, max 32.
REQ-002 Parameter DATA_WIDTH, default 32: pwdata/prdata width, 8/16/32.
REQ-003 Parameter MEM_DEPTH, default 16: number of DATA_WIDTH-bit words.
REQ-004 Parameter BASE_ADDR, default 0: byte address of word 0.
REQ-005 Parameter WAIT_STATES, default 0: pready-low cycles per access, range 0-15.
REQ-006 Parameter PRIV_WRITE_ONLY, default 0: if 1, writes require pprot[0]=1.
REQ-007 The block SHALL use one clock and an asynchronous active-low reset.
REQ-008 pclk  in  1  rising-edge clock.
REQ-009 preset_n  in  1  asynchronous active-low reset.
REQ-010 pselx  in  1  select for this completer.
REQ-011 penable  in  1  access phase.
REQ-012 pwrite  in  1  1=WRITE, 0=READ.
REQ-013 paddr  in  ADDRESS_WIDTH  byte address.
REQ-014 pwdata  in  DATA_WIDTH  write data.
REQ-015 pstrb  in  DATA_WIDTH/8  write byte strobes.
REQ-016 pprot  in  3  protection type.
REQ-017 pready  out  1  transfer complete.
REQ-018 prdata  out  DATA_WIDTH  read data.
REQ-019 pslverr  out  1  0=NO_ERROR, 1=ERROR.

Function
REQ-020 The FSM SHALL have states IDLE, SETUP and ACCESS.
- IDLE->SETUP on pselx=1 and penable=0.
- SETUP->ACCESS unconditionally.
- ACCESS->IDLE on the pready=1 cycle.
- Any state->IDLE when pselx=0.
REQ-021 In SETUP the block SHALL register paddr, pwrite, pwdata, pstrb and pprot, and load the wait counter with WAIT_STATES.
REQ-022 In ACCESS the block SHALL hold pready=0 while the counter is nonzero and decrement it each cycle.
- pready=1 in ACCESS cycle WAIT_STATES+1.
- pready is registered; it is never combinational from inputs.
REQ-023 pready, prdata and pslverr SHALL be driven nonzero only in the completing ACCESS cycle; all three are 0 otherwise.
REQ-024 Word index SHALL be (paddr-BASE_ADDR)>>log2(DATA_WIDTH/8).
REQ-025 An error SHALL be flagged, with pslverr=1 on the completing cycle, for any of:
- paddr<BASE_ADDR;
- index>=MEM_DEPTH;
- paddr not DATA_WIDTH/8-aligned;
- a write with PRIV_WRITE_ONLY=1 and pprot[0]=0;
- a read with pstrb!=0.
REQ-026 On an error the block SHALL leave memory unchanged and return prdata=0.
REQ-027 A good write SHALL update only byte lanes with pstrb[i]=1, committing on the completing edge.
- pstrb=0 on a good write: no update, pslverr=0.
REQ-028 A good read SHALL return the memory word, including any write committed in the immediately preceding transfer.
REQ-029 penable=1 while in IDLE SHALL be ignored: no state change, no memory access, no error.
REQ-030 pselx falling before pready SHALL abort the transfer: no write, outputs 0, next state IDLE.
REQ-031 Back-to-back transfers SHALL work: ACCESS completion followed directly by a new SETUP.
REQ-032 Input changes during ACCESS SHALL be ignored; only the values captured in SETUP are used.

Reset
REQ-033 preset_n=0 SHALL asynchronously force:
- state=IDLE, counter=0;
- pready=0, prdata=0, pslverr=0;
- all memory words=0.
REQ-034 Reset asserted mid-transfer SHALL discard the transfer, with no partial write.
REQ-035 After reset release the block SHALL accept a SETUP on the first clock edge.

Verification
V-1 Defaults, WAIT_STATES=0: write 0xDEADBEEF to 0x4 with pstrb=0xF, then read 0x4 -> pready=1 in first ACCESS cycle of each transfer; read prdata=0xDEADBEEF, pslverr=0.
V-2 WAIT_STATES=3: read 0x0 after reset -> pready low 3 ACCESS cycles, high in the 4th; prdata=0.
V-3 Byte strobes: word 0x8 holds 0x11223344; write 0xAABBCCDD with pstrb=0x5 -> readback 0x11BB33DD.
V-4 Errors -> pslverr=1, prdata=0, memory unchanged, for each of:
- read 0x40 (out of range, MEM_DEPTH=16);
- write 0x2 (unaligned);
- PRIV_WRITE_ONLY=1 write with pprot=3'b000.
V-5 Abort and reset:
- pselx dropped during a WAIT_STATES=3 write -> word unchanged, FSM in IDLE;
- preset_n pulsed low mid-ACCESS -> all outputs 0 immediately, memory cleared.
V-6 Back-to-back write 0x0 / read 0x0 with no IDLE cycle between -> read returns the just-written data.

Source files
------------

// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB completer backed by a small register-file memory.
// Three-state transfer FSM. Wait states are programmable. pready, prdata and
// pslverr are all registered. Byte-strobed writes commit on the completing edge.
module apb_slave_mem #(
    parameter int          ADDRESS_WIDTH   = 32,
    parameter int          DATA_WIDTH      = 32,
    parameter int          MEM_DEPTH       = 16,
    parameter int unsigned BASE_ADDR       = 0,
    parameter int          WAIT_STATES     = 0,
    parameter int          PRIV_WRITE_ONLY = 0
) (
    input  logic                       pclk,
    input  logic                       preset_n,
    input  logic                       pselx,
    input  logic                       penable,
    input  logic                       pwrite,
    input  logic [ADDRESS_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]      pwdata,
    input  logic [DATA_WIDTH/8-1:0]    pstrb,
    input  logic [2:0]                 pprot,
    output logic                       pready,
    output logic [DATA_WIDTH-1:0]      prdata,
    output logic                       pslverr
);

    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int IDX_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [ADDRESS_WIDTH-1:0] BASE_A     = ADDRESS_WIDTH'(BASE_ADDR);
    localparam logic [ADDRESS_WIDTH-1:0] DEPTH_A    = ADDRESS_WIDTH'(MEM_DEPTH);
    localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK = ADDRESS_WIDTH'(STRB_W - 1);
    localparam logic [3:0]               WAIT_LOAD  = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t                    state_reg, state_next;
    logic [3:0]                cnt_reg, cnt_next;
    logic                      pready_reg, pready_next;
    logic [DATA_WIDTH-1:0]     prdata_reg, prdata_next;
    logic                      pslverr_reg, pslverr_next;
    logic                      complete;

    // Transfer attributes captured in the bus setup phase
    logic [ADDRESS_WIDTH-1:0]  addr_reg;
    logic                      write_reg;
    logic [DATA_WIDTH-1:0]     wdata_reg;
    logic [STRB_W-1:0]         strb_reg;
    logic [2:0]                prot_reg;
    logic                      capture_en;

    // Decode of the captured address
    logic [ADDRESS_WIDTH-1:0]  offset;
    logic [ADDRESS_WIDTH-1:0]  word_index;
    logic [IDX_W-1:0]          mem_idx;
    logic                      access_err;
    logic                      commit_wr;
    logic [DATA_WIDTH-1:0]     mem_rd [MEM_DEPTH];

    // Only the privilege bit of pprot changes behaviour; the other two are carried along
    logic                      prot_unused;
    assign prot_unused = ^prot_reg[2:1];

    // Setup phase is recognised only from IDLE; penable=1 seen in IDLE is ignored
    assign capture_en = (state_reg == IDLE) && pselx && !penable;

    assign offset     = addr_reg - BASE_A;
    assign word_index = offset >> ADDR_LSB;
    assign mem_idx    = word_index[IDX_W-1:0];

    assign access_err = (addr_reg < BASE_A)
                     || (word_index >= DEPTH_A)
                     || ((addr_reg & ALIGN_MASK) != '0)
                     || (write_reg && (PRIV_WRITE_ONLY != 0) && !prot_reg[0])
                     || (!write_reg && (strb_reg != '0));

    // A write lands on the edge that ends the completing cycle, provided the requester is still selecting us
    assign commit_wr = (state_reg == ACCESS) && pready_reg && pselx && write_reg && !access_err;

    // Capture the setup-phase attributes; later input changes are ignored
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            addr_reg  <= '0;
            write_reg <= 1'b0;
            wdata_reg <= '0;
            strb_reg  <= '0;
            prot_reg  <= '0;
        end else if (capture_en) begin
            addr_reg  <= paddr;
            write_reg <= pwrite;
            wdata_reg <= pwdata;
            strb_reg  <= pstrb;
            prot_reg  <= pprot;
        end
    end

    // State, wait counter and registered response outputs
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            pready_reg  <= 1'b0;
            prdata_reg  <= '0;
            pslverr_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            pready_reg  <= pready_next;
            prdata_reg  <= prdata_next;
            pslverr_reg <= pslverr_next;
        end
    end

    // Next-state logic; the response is prepared one edge ahead so pready stays registered
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        pready_next  = 1'b0;
        prdata_next  = '0;
        pslverr_next = 1'b0;
        complete     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (pselx && !penable) begin
                    state_next = SETUP;
                end
            end
            SETUP: begin
                state_next = ACCESS;
                cnt_next   = WAIT_LOAD;
                complete   = (WAIT_LOAD == 4'd0);
            end
            ACCESS: begin
                if (pready_reg) begin
                    state_next = IDLE;
                end else if (cnt_reg != 4'd0) begin
                    cnt_next = cnt_reg - 4'd1;
                    complete = (cnt_reg == 4'd1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Deselection aborts whatever is in flight
        if (!pselx) begin
            state_next = IDLE;
            cnt_next   = '0;
            complete   = 1'b0;
        end

        if (complete) begin
            pready_next  = 1'b1;
            pslverr_next = access_err;
            if (!access_err && !write_reg) begin
                prdata_next = mem_rd[mem_idx];
            end
        end
    end

    // Memory words: each is its own register so reset can clear the whole array at once
    genvar gi;
    generate
        for (gi = 0; gi < MEM_DEPTH; gi++) begin : g_word
            logic [DATA_WIDTH-1:0] word_reg;

            // Byte-lane update of one word on a committed write
            always_ff @(posedge pclk or negedge preset_n) begin
                if (!preset_n) begin
                    word_reg <= '0;
                end else if (commit_wr && (mem_idx == IDX_W'(gi))) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (strb_reg[b]) begin
                            word_reg[8*b +: 8] <= wdata_reg[8*b +: 8];
                        end
                    end
                end
            end

            assign mem_rd[gi] = word_reg;
        end
    endgenerate

    assign pready  = pready_reg;
    assign prdata  = prdata_reg;
    assign pslverr = pslverr_reg;

endmodule
